// File: rtl/fetch_buffer_if.sv
// fetch_buffer_if
//   Bundles the two memory-side channels and the ID-side channel of the
//   instruction fetch buffer.
//   imem request : imem_req_valid / imem_req_ready / imem_req_addr
//   imem response: imem_rsp_valid / imem_rsp_data (in order, never stalled)
//   ID stage     : id_valid / id_ready / id_pc / id_pc4 / id_instr
//   modport master : the fetch buffer itself
//   modport slave  : memory + ID stage (environment)
`timescale 1ns/1ps
interface fetch_buffer_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic [31:0] id_instr;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    output id_valid, id_pc, id_pc4, id_instr,
    input  id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    input  id_valid, id_pc, id_pc4, id_instr,
    output id_ready
  );
endinterface

// File: rtl/fetch_buffer.sv
// fetch_buffer
//   Instruction-fetch buffer. Takes the PC generator's current address,
//   issues in-order requests to instruction memory, and queues returned
//   instructions in a DEPTH-entry ring for the ID stage. Drives keep_pc to
//   stall the PC whenever the current address is not accepted. A flush
//   (taken branch) empties the ring and discards responses still in flight.
//
// Ports
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   pc_if    in   current fetch address
//   keep_pc  out  hold the PC this cycle
//   flush    in   redirect pulse; wins over every other event
//   bus      fetch_buffer_if.master (imem request/response, ID channel)
//
// Optional feature (macro FETCH_BUF_PERF_EN):
//   perf_stall_cnt out 32  cycles with keep_pc = 1 (wrapping)
//   perf_drop_cnt  out 32  discarded responses (wrapping)
`timescale 1ns/1ps
module fetch_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_if,
  output logic        keep_pc,
  input  logic        flush,
  fetch_buffer_if.master bus
`ifdef FETCH_BUF_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_drop_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] alloc_ptr;
  logic [PW-1:0] fill_ptr;
  logic [PW-1:0] head_ptr;
  logic [CW-1:0] reserved;
  logic [CW-1:0] drop_cnt;
  // Requests accepted on the current path whose response has not arrived.
  // Becomes the new drop_cnt on a flush.
  logic [CW-1:0] pending;
  logic [DEPTH-1:0] filled;

  logic [31:0] pc_mem    [DEPTH];
  logic [31:0] instr_mem [DEPTH];

  logic req_valid;
  logic req_fire;
  logic rsp_take;
  logic rsp_drop;
  logic id_valid_int;
  logic pop;

  always_comb begin
    req_valid    = !flush && (reserved != CW'(DEPTH)) && (drop_cnt == '0);
    req_fire     = req_valid && bus.imem_req_ready;
    // A response arriving in a flush cycle belongs to the old path.
    rsp_take     = bus.imem_rsp_valid && (drop_cnt == '0) && !flush;
    rsp_drop     = bus.imem_rsp_valid && !rsp_take;
    id_valid_int = (reserved != '0) && filled[head_ptr];
    pop          = id_valid_int && bus.id_ready && !flush;
    keep_pc      = !flush && !req_fire;
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_if;
  assign bus.id_valid       = id_valid_int;
  assign bus.id_pc          = pc_mem[head_ptr];
  assign bus.id_pc4         = pc_mem[head_ptr] + 32'd4;
  assign bus.id_instr       = instr_mem[head_ptr];

  // Payload storage; contents are only meaningful while the filled bit and
  // reserved count say so, so no reset is needed.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      pc_mem[alloc_ptr] <= pc_if;
    end
    if (rsp_take) begin
      instr_mem[fill_ptr] <= bus.imem_rsp_data;
    end
  end

  // Pointers and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      reserved  <= '0;
      drop_cnt  <= '0;
      pending   <= '0;
    end else if (flush) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      reserved  <= '0;
      pending   <= '0;
      // Either drop_cnt or pending is zero here (no requests issue while
      // dropping), so the sum is the outstanding count; a response in this
      // cycle is already one of them.
      drop_cnt  <= drop_cnt + pending - CW'(bus.imem_rsp_valid);
    end else begin
      if (req_fire) begin
        alloc_ptr <= alloc_ptr + PW'(1);
      end
      if (rsp_take) begin
        fill_ptr <= fill_ptr + PW'(1);
      end
      if (pop) begin
        head_ptr <= head_ptr + PW'(1);
      end
      if (rsp_drop) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
      pending  <= pending + CW'(req_fire) - CW'(rsp_take);
      reserved <= reserved + CW'(req_fire) - CW'(pop);
    end
  end

  // Per-slot filled bits. Allocation and fill never target the same slot in
  // one cycle: a slot's response arrives at least a cycle after it is
  // reserved.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_filled
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          filled[gi] <= 1'b0;
        end else if (flush) begin
          filled[gi] <= 1'b0;
        end else if (req_fire && (alloc_ptr == PW'(gi))) begin
          filled[gi] <= 1'b0;
        end else if (rsp_take && (fill_ptr == PW'(gi))) begin
          filled[gi] <= 1'b1;
        end
      end
    end
  endgenerate

`ifdef FETCH_BUF_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_drop_cnt  <= '0;
    end else begin
      if (keep_pc) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if (rsp_drop) begin
        perf_drop_cnt <= perf_drop_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Instruction-fetch buffer that consumes the fetch address stream from the PC generator, issues in-order requests to instruction memory over a valid/ready channel, and holds returned instructions in a DEPTH-entry queue for the ID stage. It is the back-pressure source for the PC: it drives `keep_pc` whenever the current `pc_if` is not accepted by memory. On a taken branch it discards all wrong-path state, including responses still in flight.

## Interface
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pc_if`  in  32  current fetch address from the PC generator.
- `keep_pc`  out  1  hold PC this cycle.
- `flush`  in  1  taken branch / redirect; same-cycle pulse with the PC generator's `branch_op`.
- `imem_req_valid`  out  1  request valid.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_req_addr`  out  32  request address (= `pc_if`).
- `imem_rsp_valid`  in  1  response valid; in order, no back-pressure, ≥1 cycle after acceptance.
- `imem_rsp_data`  in  32  instruction word.
- `id_valid`  out  1  head entry holds an instruction.
- `id_ready`  in  1  ID stage consumes head.
- `id_pc`  out  32  head address.
- `id_pc4`  out  32  `id_pc + 4`, modulo 2^32.
- `id_instr`  out  32  head instruction.

## Operation
- Ring of DEPTH slots, each {pc, instr, filled}. Three pointers, each `$clog2(DEPTH)` bits, wrapping modulo DEPTH:
  - `alloc`: next slot to reserve.
  - `fill`: next slot awaiting a response.
  - `head`: next slot to read.
- `reserved` counter, `$clog2(DEPTH)+1` bits, counts allocated-not-popped slots (0..DEPTH).
- `drop_cnt` counter, same width, counts in-flight responses to discard.
- `imem_req_valid = !flush && reserved < DEPTH && drop_cnt == 0`.
- `imem_req_addr = pc_if`.
- Request accepted (`valid && ready`): write `pc_if` into slot `alloc`, clear its filled bit, `alloc++`, `reserved++`.
- `keep_pc = !flush && !(imem_req_valid && imem_req_ready)`. It is forced low on flush so the PC generator loads the branch target.
- Response, `drop_cnt > 0`: discard the data, `drop_cnt--`.
- Response, `drop_cnt == 0`: write `imem_rsp_data` into slot `fill`, set filled, `fill++`.
- `id_valid = (reserved != 0) && filled[head]`.
- Pop on `id_valid && id_ready`: `head++`, `reserved--`.
- Same-cycle request and pop: `reserved` unchanged.
- Flush:
  - Set `alloc = fill = head = 0`, `reserved = 0`, all filled bits = 0.
  - Set `drop_cnt` = number of slots allocated but not filled.
  - A response in the flush cycle is dropped and already subtracted from that count.
  - A pop in the flush cycle is ignored.
  - Flush has priority over every other event.
- Reset state:
  - All pointers and counters 0, filled bits 0.
  - `id_valid = 0`, `imem_req_valid = !flush`.
  - `keep_pc = !flush && !imem_req_ready`.

## Timing
- Request issued in the same cycle as the `pc_if` it carries. PC advances on the following edge.
- Response in cycle N: `id_valid` rises in N+1 at the earliest. There is no response-to-ID bypass.
- Throughput: 1 instruction/cycle with single-cycle memory and `id_ready` held high.
- Full (`reserved == DEPTH`): `imem_req_valid = 0`, `keep_pc = 1` until a pop.
- After a flush with in-flight responses, requests resume in the cycle after the last dropped response.
- No in-flight responses at flush: requests resume in the cycle after the flush, using the branch target.
- Reset asserted mid-operation: all state cleared immediately. The bench must not deliver stale responses after reset.

## Configuration
- `FETCH_BUF_PERF_EN` defined: adds output `perf_stall_cnt` (32) and output `perf_drop_cnt` (32), both reset to 0, both wrapping.
  - `perf_stall_cnt` increments each cycle `keep_pc == 1`.
  - `perf_drop_cnt` increments per discarded response.
- Undefined: these ports and their counters are absent. Behaviour is otherwise identical.

## Test plan
- Single-cycle memory, `id_ready = 1`, start `pc_if = 0x100`: ID sees pc 0x100, 0x104, 0x108 on consecutive cycles, first one 2 cycles after reset release; `keep_pc` stays 0.
- `id_ready = 0`, DEPTH=4: exactly 4 requests (0x100–0x10C) accepted, then `keep_pc = 1`. One pop, then exactly one new request 0x110.
- `imem_req_ready = 0` for 3 cycles: `keep_pc = 1` for those 3 cycles, `imem_req_addr` holds the same value, no entry allocated.
- 2 requests in flight, flush with target 0x200: `keep_pc = 0` in the flush cycle, `id_valid = 0` next cycle, the 2 old responses are discarded, the first ID entry is pc 0x200.
- Flush coincident with a response and a pop: the response is dropped, `drop_cnt` counts only the remaining outstanding, and `reserved = 0` after the edge.
- With `FETCH_BUF_PERF_EN`: the flush scenario yields `perf_drop_cnt = 2`, and the full-queue scenario increments `perf_stall_cnt` once per held cycle.
